// File: rtl/x_corr_feeder.sv
// Captures x/y sample blocks and replays them as circular-lag vectors for x_corr.
// Define XCORR_FEEDER_CONJ_EN to emit the conjugate of y (saturating yq negation).
module x_corr_feeder #(
    parameter int xi_bits             = 12,
    parameter int xq_bits             = 12,
    parameter int yi_bits             = 12,
    parameter int yq_bits             = 12,
    parameter int length              = 5,
    parameter int length_counter_bits = 3
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic signed [xi_bits-1:0]             xi_in,
    input  logic signed [xq_bits-1:0]             xq_in,
    input  logic signed [yi_bits-1:0]             yi_in,
    input  logic signed [yq_bits-1:0]             yq_in,
    input  logic                                  m_axis_tvalid,
    output logic                                  s_axis_tready,
    output logic signed [xi_bits-1:0]             xi,
    output logic signed [xq_bits-1:0]             xq,
    output logic signed [yi_bits-1:0]             yi,
    output logic signed [yq_bits-1:0]             yq,
    output logic                                  s_axis_tvalid,
    input  logic                                  m_axis_tready,
    output logic                                  tlast,
    output logic [length_counter_bits-1:0]        lag
);

    localparam int CB = length_counter_bits;
    localparam logic [CB-1:0] LAST  = CB'(length - 1);
    localparam logic [CB-1:0] ONE   = CB'(1);
    localparam logic [CB:0]   LEN_W = (CB + 1)'(length);

    typedef enum logic {LOAD, STREAM} state_t;

    state_t state, state_d;

    logic [CB-1:0] wr_idx, wr_idx_d;
    logic [CB-1:0] n, n_d, lag_d;
    logic          tready_d, tvalid_d, tlast_d;
    logic          load_hs, out_hs, load_out;
    logic [CB-1:0] rd_n, rd_lag, y_idx;
    logic [CB:0]   y_sum;

    logic signed [xi_bits-1:0] x_mem_i [length];
    logic signed [xq_bits-1:0] x_mem_q [length];
    logic signed [yi_bits-1:0] y_mem_i [length];
    logic signed [yq_bits-1:0] y_mem_q [length];

    logic signed [yq_bits-1:0] yq_raw, yq_sel;

    assign load_hs = (state == LOAD) && m_axis_tvalid && s_axis_tready;
    assign out_hs  = (state == STREAM) && s_axis_tvalid && m_axis_tready;

    always_comb begin
        state_d  = state;
        wr_idx_d = wr_idx;
        n_d      = n;
        lag_d    = lag;
        tready_d = s_axis_tready;
        tvalid_d = s_axis_tvalid;
        tlast_d  = tlast;
        load_out = 1'b0;
        rd_n     = '0;
        rd_lag   = '0;
        unique case (state)
            LOAD: begin
                tready_d = 1'b1;
                if (load_hs) begin
                    if (wr_idx == LAST) begin
                        wr_idx_d = '0;
                        tready_d = 1'b0;
                        state_d  = STREAM;
                        tvalid_d = 1'b1;
                        n_d      = '0;
                        lag_d    = '0;
                        load_out = 1'b1;
                    end else begin
                        wr_idx_d = wr_idx + ONE;
                    end
                end
            end
            STREAM: begin
                if (out_hs) begin
                    if (n != LAST) begin
                        n_d      = n + ONE;
                        load_out = 1'b1;
                        rd_n     = n + ONE;
                        rd_lag   = lag;
                    end else if (lag != LAST) begin
                        n_d      = '0;
                        lag_d    = lag + ONE;
                        load_out = 1'b1;
                        rd_lag   = lag + ONE;
                    end else begin
                        n_d      = '0;
                        lag_d    = '0;
                        tvalid_d = 1'b0;
                        state_d  = LOAD;
                        tready_d = 1'b1;
                    end
                end
            end
        endcase
        if (load_out) tlast_d = (rd_n == LAST);
        else if (!tvalid_d) tlast_d = 1'b0;
    end

    // Circular y index without a divider: sum never reaches 2*length.
    always_comb begin
        y_sum = {1'b0, rd_n} + {1'b0, rd_lag};
        y_idx = (y_sum >= LEN_W) ? CB'(y_sum - LEN_W) : CB'(y_sum);
    end

    assign yq_raw = y_mem_q[y_idx];

`ifdef XCORR_FEEDER_CONJ_EN
    localparam logic signed [yq_bits-1:0] YQ_MIN = {1'b1, {(yq_bits-1){1'b0}}};
    localparam logic signed [yq_bits-1:0] YQ_MAX = {1'b0, {(yq_bits-1){1'b1}}};
    assign yq_sel = (yq_raw == YQ_MIN) ? YQ_MAX : -yq_raw;
`else
    assign yq_sel = yq_raw;
`endif

    always_ff @(posedge clk) begin
        if (load_hs && !reset) begin
            x_mem_i[wr_idx] <= xi_in;
            x_mem_q[wr_idx] <= xq_in;
            y_mem_i[wr_idx] <= yi_in;
            y_mem_q[wr_idx] <= yq_in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= LOAD;
            wr_idx        <= '0;
            n             <= '0;
            lag           <= '0;
            s_axis_tready <= 1'b0;
            s_axis_tvalid <= 1'b0;
            tlast         <= 1'b0;
        end else begin
            state         <= state_d;
            wr_idx        <= wr_idx_d;
            n             <= n_d;
            lag           <= lag_d;
            s_axis_tready <= tready_d;
            s_axis_tvalid <= tvalid_d;
            tlast         <= tlast_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            xi <= '0;
            xq <= '0;
            yi <= '0;
            yq <= '0;
        end else if (load_out) begin
            xi <= x_mem_i[rd_n];
            xq <= x_mem_q[rd_n];
            yi <= y_mem_i[y_idx];
            yq <= yq_sel;
        end
    end

endmodule

// File: tb/tb_x_corr_feeder.sv
// Randomized self-checking bench for x_corr_feeder against a lag-vector model.
module tb_x_corr_feeder;

    localparam int L = 5;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic signed [11:0] xi_in = '0, xq_in = '0, yi_in = '0, yq_in = '0;
    logic m_axis_tvalid = 1'b0;
    logic m_axis_tready = 1'b0;
    logic s_axis_tready, s_axis_tvalid, tlast;
    logic [2:0] lag;
    logic signed [11:0] xi, xq, yi, yq;

    int nvec = 0;
    int nerr = 0;

    logic signed [11:0] bx_i [L];
    logic signed [11:0] bx_q [L];
    logic signed [11:0] by_i [L];
    logic signed [11:0] by_q [L];

    x_corr_feeder dut (
        .clk(clk), .reset(reset),
        .xi_in(xi_in), .xq_in(xq_in), .yi_in(yi_in), .yq_in(yq_in),
        .m_axis_tvalid(m_axis_tvalid), .s_axis_tready(s_axis_tready),
        .xi(xi), .xq(xq), .yi(yi), .yq(yq),
        .s_axis_tvalid(s_axis_tvalid), .m_axis_tready(m_axis_tready),
        .tlast(tlast), .lag(lag)
    );

    always #5 clk = ~clk;

    function automatic logic signed [11:0] exp_yq(input logic signed [11:0] v);
`ifdef XCORR_FEEDER_CONJ_EN
        int e;
        e = -int'(v);
        if (e > 2047) e = 2047;
        return 12'(e);
`else
        return v;
`endif
    endfunction

    task automatic rand_block();
        for (int k = 0; k < L; k++) begin
            bx_i[k] = 12'($urandom);
            bx_q[k] = 12'($urandom);
            by_i[k] = 12'($urandom);
            by_q[k] = 12'($urandom);
        end
    endtask

    task automatic load_block(input bit gap, input string nm);
        int cnt = 0;
        int cyc = 0;
        bit v;
        while (cnt < L && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
            v = gap ? (cyc % 3 == 0) : 1'b1;
            m_axis_tvalid = v;
            xi_in = bx_i[cnt];
            xq_in = bx_q[cnt];
            yi_in = by_i[cnt];
            yq_in = by_q[cnt];
            if (v && s_axis_tready) cnt++;
        end
        @(posedge clk); #1;
        m_axis_tvalid = 1'b0;
        nvec++;
        if (cnt != L || s_axis_tvalid !== 1'b1 || s_axis_tready !== 1'b0) begin
            nerr++;
            $display("FAIL %s load_entry: loads=%0d valid=%b ready=%b, required loads=5 valid=1 ready=0",
                     nm, cnt, s_axis_tvalid, s_axis_tready);
        end
    endtask

    task automatic run_stream(input bit stall, input bit junk, input string nm);
        int t = 0;
        int cyc = 0;
        int n, lg, yk;
        bit r;
        bit prev_stall = 1'b0;
        while (t < L * L && cyc < 1000) begin
            if (s_axis_tvalid) begin
                n = t % L;
                lg = t / L;
                yk = (n + lg) % L;
                nvec++;
                if (xi !== bx_i[n] || xq !== bx_q[n] || yi !== by_i[yk] ||
                    yq !== exp_yq(by_q[yk]) || tlast !== (n == L - 1) ||
                    lag !== 3'(lg)) begin
                    nerr++;
                    $display("FAIL %s pair t=%0d: got xi=%0d xq=%0d yi=%0d yq=%0d tlast=%b lag=%0d, required xi=%0d xq=%0d yi=%0d yq=%0d tlast=%b lag=%0d",
                             nm, t, xi, xq, yi, yq, tlast, lag, bx_i[n], bx_q[n],
                             by_i[yk], exp_yq(by_q[yk]), (n == L - 1), lg);
                end
            end else if (prev_stall) begin
                nvec++;
                nerr++;
                $display("FAIL %s valid_drop t=%0d: valid=0, required 1", nm, t);
            end
            r = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            m_axis_tready = r;
            prev_stall = s_axis_tvalid && !r;
            if (s_axis_tvalid && r) t++;
            m_axis_tvalid = (junk && t < L * L) ? 1'($urandom_range(0, 1)) : 1'b0;
            if (junk) begin
                xi_in = 12'($urandom);
                xq_in = 12'($urandom);
                yi_in = 12'($urandom);
                yq_in = 12'($urandom);
            end
            @(posedge clk); #1;
            cyc++;
        end
        m_axis_tready = 1'b0;
        m_axis_tvalid = 1'b0;
        nvec++;
        if (t != L * L || s_axis_tvalid !== 1'b0 || s_axis_tready !== 1'b1 ||
            tlast !== 1'b0 || lag !== 3'd0) begin
            nerr++;
            $display("FAIL %s run_end: transfers=%0d valid=%b ready=%b tlast=%b lag=%0d, required 25 0 1 0 0",
                     nm, t, s_axis_tvalid, s_axis_tready, tlast, lag);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        nvec++;
        if (s_axis_tvalid !== 1'b0 || s_axis_tready !== 1'b0 || tlast !== 1'b0 ||
            lag !== 3'd0 || xi !== 12'sd0 || xq !== 12'sd0 || yi !== 12'sd0 || yq !== 12'sd0) begin
            nerr++;
            $display("FAIL reset_state: valid=%b ready=%b tlast=%b lag=%0d xi=%0d xq=%0d yi=%0d yq=%0d, required all 0",
                     s_axis_tvalid, s_axis_tready, tlast, lag, xi, xq, yi, yq);
        end
        reset = 1'b0;
        @(posedge clk); #1;
        nvec++;
        if (s_axis_tready !== 1'b1 || s_axis_tvalid !== 1'b0) begin
            nerr++;
            $display("FAIL reset_release: ready=%b valid=%b, required ready=1 valid=0",
                     s_axis_tready, s_axis_tvalid);
        end
    endtask

    task automatic set_ramp();
        for (int k = 0; k < L; k++) begin
            bx_i[k] = 12'(k + 1);
            bx_q[k] = 12'(-(k + 1));
            by_i[k] = 12'(10 * (k + 1));
            by_q[k] = 12'(k - 2);
        end
    endtask

    task automatic test_back_to_back_ramp();
        set_ramp();
        load_block(1'b0, "ramp");
        run_stream(1'b0, 1'b0, "ramp");
    endtask

    task automatic test_stall();
        set_ramp();
        load_block(1'b0, "stall");
        run_stream(1'b1, 1'b0, "stall");
    endtask

    task automatic test_gapped_load();
        rand_block();
        load_block(1'b1, "gapped");
        run_stream(1'b0, 1'b1, "gapped");
    endtask

    task automatic test_conj();
        rand_block();
        by_q[0] = -12'sd2048;
        by_q[1] = 12'sd5;
        by_q[2] = 12'sd2047;
        by_q[3] = -12'sd1;
        by_q[4] = 12'sd0;
        load_block(1'b0, "conj");
        run_stream(1'b1, 1'b0, "conj");
    endtask

    task automatic test_reset_mid_stream();
        rand_block();
        load_block(1'b0, "midrst");
        m_axis_tready = 1'b1;
        repeat (7) @(posedge clk);
        #1;
        m_axis_tready = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        nvec++;
        if (s_axis_tvalid !== 1'b0 || tlast !== 1'b0 || lag !== 3'd0 || s_axis_tready !== 1'b0) begin
            nerr++;
            $display("FAIL midrst_abort: valid=%b tlast=%b lag=%0d ready=%b, required 0 0 0 0",
                     s_axis_tvalid, tlast, lag, s_axis_tready);
        end
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk); #1;
        nvec++;
        if (s_axis_tready !== 1'b1 || s_axis_tvalid !== 1'b0) begin
            nerr++;
            $display("FAIL midrst_release: ready=%b valid=%b, required ready=1 valid=0",
                     s_axis_tready, s_axis_tvalid);
        end
        rand_block();
        load_block(1'b0, "midrst_reload");
        run_stream(1'b0, 1'b0, "midrst_reload");
    endtask

    task automatic test_back_to_back();
        rand_block();
        load_block(1'b0, "b2b_first");
        run_stream(1'b0, 1'b0, "b2b_first");
        rand_block();
        load_block(1'b0, "b2b_second");
        run_stream(1'b1, 1'b0, "b2b_second");
    endtask

    initial begin
        test_reset();
        test_back_to_back_ramp();
        test_stall();
        test_gapped_load();
        test_conj();
        test_reset_mid_stream();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
